// File: rtl/heartbeat_pkg.sv
// Shared heartbeat class codes, beat FSM states and default timing.
// Used by the classifier (producer) and the pulser (consumer).
package heartbeat_pkg;

   typedef enum logic [1:0] {
      HB_REST     = 2'b00,
      HB_NORMAL   = 2'b01,
      HB_ELEVATED = 2'b10,
      HB_RACING   = 2'b11
   } hb_class_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LUB  = 3'd1,
      ST_GAP  = 3'd2,
      ST_DUB  = 3'd3,
      ST_REST = 3'd4
   } hb_state_e;

   localparam int unsigned PER0_DEF = 60;
   localparam int unsigned PER1_DEF = 40;
   localparam int unsigned PER2_DEF = 28;
   localparam int unsigned PER3_DEF = 20;
   localparam int unsigned LUB_DEF  = 3;
   localparam int unsigned GAP_DEF  = 2;
   localparam int unsigned DUB_DEF  = 3;

   function automatic int unsigned min4(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c,
      input int unsigned d
   );
      int unsigned m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      if (d < m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/heartbeat_pulser.sv
// Lub-dub beat generator: class-dependent period counted in time-base
// ticks, registered beat output, start strobe and wrapping beat counter.
module heartbeat_pulser
   import heartbeat_pkg::*;
#(
   parameter int unsigned PER0 = PER0_DEF,
   parameter int unsigned PER1 = PER1_DEF,
   parameter int unsigned PER2 = PER2_DEF,
   parameter int unsigned PER3 = PER3_DEF,
   parameter int unsigned LUB  = LUB_DEF,
   parameter int unsigned GAP  = GAP_DEF,
   parameter int unsigned DUB  = DUB_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       tick,
   input  logic [1:0] heartbeat,
   output logic       beat,
   output logic       beat_strobe,
   output logic [7:0] beat_count,
   output logic [2:0] phase
);

   if ((LUB + GAP + DUB >= min4(PER0, PER1, PER2, PER3)) ||
       (PER0 > 255) || (PER1 > 255) || (PER2 > 255) || (PER3 > 255) ||
       (LUB == 0) || (DUB == 0) || (GAP == 0))
   begin : g_bad_params
      $error("heartbeat_pulser: illegal beat timing parameters");
   end

   localparam logic [7:0] P0 = 8'(PER0);
   localparam logic [7:0] P1 = 8'(PER1);
   localparam logic [7:0] P2 = 8'(PER2);
   localparam logic [7:0] P3 = 8'(PER3);
   localparam logic [7:0] E1 = 8'(LUB);
   localparam logic [7:0] E2 = 8'(LUB + GAP);
   localparam logic [7:0] E3 = 8'(LUB + GAP + DUB);

   hb_state_e  state_q, state_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic [7:0] per_q, per_d;
   logic       beat_q, beat_d;
   logic       strobe_q, strobe_d;
   logic [7:0] count_q, count_d;
   logic [7:0] pinc;
   logic [7:0] per_sel;
   logic       start;

   always_comb begin
      per_sel = P0;
      unique case (hb_class_e'(heartbeat))
         HB_REST:     per_sel = P0;
         HB_NORMAL:   per_sel = P1;
         HB_ELEVATED: per_sel = P2;
         HB_RACING:   per_sel = P3;
      endcase
   end

   // Period ends on the tick where REST has consumed per_q-1 counts
   assign start = tick &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_REST) && (pcnt_q == per_q - 8'd1)));
   assign pinc  = pcnt_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      per_d    = per_q;
      beat_d   = beat_q;
      strobe_d = 1'b0;
      count_d  = count_q;
      if (!ena) begin
         state_d = ST_IDLE;
         pcnt_d  = 8'd0;
         beat_d  = 1'b0;
      end else if (start) begin
         state_d  = ST_LUB;
         pcnt_d   = 8'd0;
         per_d    = per_sel;
         beat_d   = 1'b1;
         strobe_d = 1'b1;
         count_d  = count_q + 8'd1;
      end else if (tick) begin
         case (state_q)
            ST_LUB: begin
               pcnt_d = pinc;
               if (pinc == E1) begin
                  state_d = ST_GAP;
                  beat_d  = 1'b0;
               end
            end
            ST_GAP: begin
               pcnt_d = pinc;
               if (pinc == E2) begin
                  state_d = ST_DUB;
                  beat_d  = 1'b1;
               end
            end
            ST_DUB: begin
               pcnt_d = pinc;
               if (pinc == E3) begin
                  state_d = ST_REST;
                  beat_d  = 1'b0;
               end
            end
            ST_REST: begin
               pcnt_d = pinc;
               beat_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               pcnt_d  = 8'd0;
               beat_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pcnt_q   <= 8'd0;
         per_q    <= 8'd0;
         beat_q   <= 1'b0;
         strobe_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         per_q    <= per_d;
         beat_q   <= beat_d;
         strobe_q <= strobe_d;
         count_q  <= count_d;
      end
   end

   assign beat        = beat_q;
   assign beat_strobe = strobe_q;
   assign beat_count  = count_q;
   assign phase       = state_q;

endmodule
